// File: rtl/ex_stage_pkg.sv
// Shared MIPS32 pipeline definitions used by the execute stage: ALUOp classes, R-type funct
// codes, the internal ALU control enum and the multiply FSM states.
package ex_stage_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_LUI   = 3'b110;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MULT = 6'h18;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluNor,
    AluSlt,
    AluLui
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    MulIdle,
    MulBusy,
    MulDone
  } mul_state_e;

  function automatic alu_ctrl_e alu_decode(input logic [2:0] alu_op, input logic [5:0] funct);
    alu_ctrl_e ctrl;
    ctrl = AluAdd;
    case (alu_op)
      ALUOP_ADD: ctrl = AluAdd;
      ALUOP_SUB: ctrl = AluSub;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  ctrl = AluAdd;
          FUNCT_SUB:  ctrl = AluSub;
          FUNCT_AND:  ctrl = AluAnd;
          FUNCT_OR:   ctrl = AluOr;
          FUNCT_NOR:  ctrl = AluNor;
          FUNCT_SLT:  ctrl = AluSlt;
          // The multiplier result, when present, bypasses the ALU entirely.
          FUNCT_MULT: ctrl = AluAdd;
          default:    ctrl = AluAdd;
        endcase
      end
      ALUOP_AND: ctrl = AluAnd;
      ALUOP_OR:  ctrl = AluOr;
      ALUOP_SLT: ctrl = AluSlt;
      ALUOP_LUI: ctrl = AluLui;
      default:   ctrl = AluAdd;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/ex_stage_alu_core.sv
// Combinational 32-bit ALU for the execute stage. zero_o always reflects a - b, independent of
// the selected operation, so branch resolution never depends on the ALU control.
module ex_stage_alu_core
  import ex_stage_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [15:0] imm_i,
  input  logic [3:0]  ctrl_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  alu_ctrl_e   ctrl;
  logic [31:0] diff;

  assign ctrl   = alu_ctrl_e'(ctrl_i);
  assign diff   = a_i - b_i;
  assign zero_o = (diff == 32'd0);

  always_comb begin
    result_o = a_i + b_i;
    case (ctrl)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = diff;
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluNor:  result_o = ~(a_i | b_i);
      AluSlt:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      AluLui:  result_o = {imm_i, 16'h0000};
      default: result_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: ALU, branch/jump resolution and the EX/MEM register.
// Define MULT_EN to add the iterative shift-add multiplier (R-type funct 0x18) with stall.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_pc_plus4,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic [31:0] in_imm_ext,
  input  logic [31:0] in_jump_target,
  input  logic [4:0]  in_rt_addr,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_reg_dst,
  input  logic        in_branch,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_alu_src,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic        in_jump,
  input  logic [2:0]  in_alu_op,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_dest,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        out_reg_write,
  output logic        out_mem_to_reg,
  output logic        out_redirect,
  output logic [31:0] out_pc_target,
  output logic        out_stall
);

  logic [31:0] op_b, alu_result, br_target;
  logic [4:0]  dest;
  logic [3:0]  alu_ctrl;
  logic        zero, br_taken, jump_taken, bubble;

  logic [31:0] alu_result_d, alu_result_q, store_data_d, store_data_q, pc_target_d, pc_target_q;
  logic [4:0]  dest_d, dest_q;
  logic        mem_read_d, mem_read_q, mem_write_d, mem_write_q;
  logic        reg_write_d, reg_write_q, mem_to_reg_d, mem_to_reg_q;
  logic        redirect_d, redirect_q;

  assign op_b       = in_alu_src ? in_imm_ext : in_rt_data;
  assign dest       = in_reg_dst ? in_rd_addr : in_rt_addr;
  assign alu_ctrl   = alu_decode(in_alu_op, in_imm_ext[5:0]);
  assign br_target  = in_pc_plus4 + (in_imm_ext << 2);
  assign jump_taken = in_valid & in_jump;
  assign br_taken   = in_valid & in_branch & zero;

  ex_stage_alu_core u_alu_core (
    .a_i      (in_rs_data),
    .b_i      (op_b),
    .imm_i    (in_imm_ext[15:0]),
    .ctrl_i   (alu_ctrl),
    .result_o (alu_result),
    .zero_o   (zero)
  );

`ifdef MULT_EN
  mul_state_e  state_d, state_q;
  logic [4:0]  cnt_d, cnt_q, mul_dest_d, mul_dest_q;
  logic [31:0] acc_d, acc_q, mcand_d, mcand_q, mplier_d, mplier_q;
  logic        mul_rw_d, mul_rw_q, is_mult;

  assign is_mult   = in_valid & (in_alu_op == ALUOP_RTYPE) & (in_imm_ext[5:0] == FUNCT_MULT);
  assign out_stall = (state_q != MulIdle);
`else
  assign out_stall = 1'b0;
`endif

  always_comb begin
    bubble       = ~in_valid;
    alu_result_d = alu_result;
    store_data_d = in_rt_data;
    dest_d       = dest;
    pc_target_d  = jump_taken ? in_jump_target : br_target;
    redirect_d   = jump_taken | br_taken;
    mem_read_d   = in_mem_read;
    mem_write_d  = in_mem_write;
    reg_write_d  = in_reg_write;
    mem_to_reg_d = in_mem_to_reg;
`ifdef MULT_EN
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    mul_dest_d = mul_dest_q;
    mul_rw_d   = mul_rw_q;
    unique case (state_q)
      MulIdle: begin
        if (is_mult) begin
          state_d    = MulBusy;
          cnt_d      = 5'd0;
          acc_d      = 32'd0;
          mcand_d    = in_rs_data;
          mplier_d   = in_rt_data;
          mul_dest_d = dest;
          mul_rw_d   = in_reg_write;
          bubble     = 1'b1;
        end
      end
      MulBusy: begin
        bubble   = 1'b1;
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = MulDone;
      end
      MulDone: begin
        state_d      = MulIdle;
        bubble       = 1'b0;
        alu_result_d = acc_q;
        dest_d       = mul_dest_q;
        reg_write_d  = mul_rw_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        redirect_d   = 1'b0;
      end
      default: state_d = MulIdle;
    endcase
`endif
    // Bubbles keep their data fields but must never write, access memory or redirect.
    if (bubble) begin
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      redirect_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= 32'd0;
      store_data_q <= 32'd0;
      pc_target_q  <= 32'd0;
      dest_q       <= 5'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      redirect_q   <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      pc_target_q  <= pc_target_d;
      dest_q       <= dest_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      redirect_q   <= redirect_d;
    end
  end

`ifdef MULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MulIdle;
      cnt_q      <= 5'd0;
      acc_q      <= 32'd0;
      mcand_q    <= 32'd0;
      mplier_q   <= 32'd0;
      mul_dest_q <= 5'd0;
      mul_rw_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      mul_dest_q <= mul_dest_d;
      mul_rw_q   <= mul_rw_d;
    end
  end
`endif

  assign out_alu_result = alu_result_q;
  assign out_store_data = store_data_q;
  assign out_pc_target  = pc_target_q;
  assign out_dest       = dest_q;
  assign out_mem_read   = mem_read_q;
  assign out_mem_write  = mem_write_q;
  assign out_reg_write  = reg_write_q;
  assign out_mem_to_reg = mem_to_reg_q;
  assign out_redirect   = redirect_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: an instruction-level reference model checked every cycle, plus directed
// vectors with literal expectations. Multiply checks are built when MULT_EN is defined.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic [31:0] in_pc_plus4, in_rs_data, in_rt_data, in_imm_ext, in_jump_target;
  logic [4:0]  in_rt_addr, in_rd_addr;
  logic        in_reg_dst, in_branch, in_mem_read, in_mem_write, in_alu_src;
  logic        in_reg_write, in_mem_to_reg, in_jump;
  logic [2:0]  in_alu_op;
  logic [31:0] out_alu_result, out_store_data, out_pc_target;
  logic [4:0]  out_dest;
  logic        out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg;
  logic        out_redirect, out_stall;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  ex_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_pc_plus4    (in_pc_plus4),
    .in_rs_data     (in_rs_data),
    .in_rt_data     (in_rt_data),
    .in_imm_ext     (in_imm_ext),
    .in_jump_target (in_jump_target),
    .in_rt_addr     (in_rt_addr),
    .in_rd_addr     (in_rd_addr),
    .in_reg_dst     (in_reg_dst),
    .in_branch      (in_branch),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_alu_src     (in_alu_src),
    .in_reg_write   (in_reg_write),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_jump        (in_jump),
    .in_alu_op      (in_alu_op),
    .out_alu_result (out_alu_result),
    .out_store_data (out_store_data),
    .out_dest       (out_dest),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .out_reg_write  (out_reg_write),
    .out_mem_to_reg (out_mem_to_reg),
    .out_redirect   (out_redirect),
    .out_pc_target  (out_pc_target),
    .out_stall      (out_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] r;
    r = a + b;
    if (op == 3'd1) r = a - b;
    else if (op == 3'd3) r = a & b;
    else if (op == 3'd4) r = a | b;
    else if (op == 3'd5) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    else if (op == 3'd6) r = imm << 16;
    else if (op == 3'd2) begin
      if (imm[5:0] == 6'h22) r = a - b;
      else if (imm[5:0] == 6'h24) r = a & b;
      else if (imm[5:0] == 6'h25) r = a | b;
      else if (imm[5:0] == 6'h27) r = ~(a | b);
      else if (imm[5:0] == 6'h2A) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    end
    return r;
  endfunction

  // Reference model: what EX/MEM must hold after each edge.
  logic [31:0] e_result, e_store, e_target;
  logic [4:0]  e_dest;
  logic        e_mr, e_mw, e_rw, e_m2r, e_redir, e_stall, e_data_ok;
  int          mul_left;
  logic [31:0] mul_prod;
  logic [4:0]  mul_dest;
  logic        mul_rw;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] b;
    logic        tj, tb;
    if (!rst_n) begin
      {e_result, e_store, e_target, e_dest} <= '0;
      {e_mr, e_mw, e_rw, e_m2r, e_redir, e_stall} <= '0;
      e_data_ok <= 1'b1;
      mul_left  <= 0;
    end else if (mul_left > 0) begin
      mul_left <= mul_left - 1;
      {e_mr, e_mw, e_m2r, e_redir} <= '0;
      e_store <= in_rt_data;
      if (mul_left == 1) begin
        e_result  <= mul_prod;
        e_dest    <= mul_dest;
        e_rw      <= mul_rw;
        e_stall   <= 1'b0;
        e_data_ok <= 1'b1;
      end else begin
        e_rw      <= 1'b0;
        e_stall   <= 1'b1;
        e_data_ok <= 1'b0;
      end
    end else begin
      b  = in_alu_src ? in_imm_ext : in_rt_data;
      tj = in_valid & in_jump;
      tb = in_valid & in_branch & (in_rs_data == b);
      e_result  <= ref_alu(in_alu_op, in_rs_data, b, in_imm_ext);
      e_store   <= in_rt_data;
      e_dest    <= in_reg_dst ? in_rd_addr : in_rt_addr;
      e_redir   <= tj | tb;
      e_target  <= tj ? in_jump_target : in_pc_plus4 + in_imm_ext * 4;
      e_mr      <= in_valid & in_mem_read;
      e_mw      <= in_valid & in_mem_write;
      e_rw      <= in_valid & in_reg_write;
      e_m2r     <= in_valid & in_mem_to_reg;
      e_stall   <= 1'b0;
      e_data_ok <= 1'b1;
`ifdef MULT_EN
      if (in_valid && in_alu_op == 3'd2 && in_imm_ext[5:0] == 6'h18) begin
        mul_left  <= 33;
        mul_prod  <= in_rs_data * in_rt_data;
        mul_dest  <= in_reg_dst ? in_rd_addr : in_rt_addr;
        mul_rw    <= in_reg_write;
        {e_mr, e_mw, e_rw, e_m2r, e_redir} <= '0;
        e_stall   <= 1'b1;
        e_data_ok <= 1'b0;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_redirect", {31'd0, out_redirect}, {31'd0, e_redir});
      chk("cyc_ctrl", {28'd0, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg},
          {28'd0, e_mr, e_mw, e_rw, e_m2r});
      chk("cyc_stall", {31'd0, out_stall}, {31'd0, e_stall});
      if (e_redir) chk("cyc_target", out_pc_target, e_target);
      if (e_data_ok) begin
        chk("cyc_result", out_alu_result, e_result);
        chk("cyc_dest", {27'd0, out_dest}, {27'd0, e_dest});
        chk("cyc_store", out_store_data, e_store);
      end
    end
  end

  task automatic clear_in();
    in_valid = 0; in_pc_plus4 = 0; in_rs_data = 0; in_rt_data = 0; in_imm_ext = 0;
    in_jump_target = 0; in_rt_addr = 0; in_rd_addr = 0; in_reg_dst = 0; in_branch = 0;
    in_mem_read = 0; in_mem_write = 0; in_alu_src = 0; in_reg_write = 0; in_mem_to_reg = 0;
    in_jump = 0; in_alu_op = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rvec(input string name, input logic [2:0] op, input logic [31:0] imm,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] exp);
    clear_in();
    in_valid = 1; in_alu_op = op; in_imm_ext = imm; in_rs_data = rs; in_rt_data = rt;
    in_reg_dst = 1; in_rd_addr = 5'd7; in_reg_write = 1;
    tick();
    chk(name, out_alu_result, exp);
  endtask

  initial begin
    int stall_cnt;
    clear_in();
    tick();
    chk_en = 1'b1;
    chk("rst_result", out_alu_result, 32'd0);
    chk("rst_ctrl", {26'd0, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
                     out_redirect, out_stall}, 32'd0);
    tick();
    rst_n = 1'b1;

    // add via R-type
    clear_in();
    in_valid = 1; in_alu_op = 3'b010; in_imm_ext = 32'h20; in_rs_data = 5; in_rt_data = 7;
    in_reg_dst = 1; in_rd_addr = 5'd3; in_reg_write = 1;
    tick();
    chk("add_result", out_alu_result, 32'd12);
    chk("add_dest", {27'd0, out_dest}, 32'd3);
    chk("add_rw", {31'd0, out_reg_write}, 32'd1);
    chk("add_redir", {31'd0, out_redirect}, 32'd0);

    // addi with negative immediate, dest from rt
    clear_in();
    in_valid = 1; in_alu_src = 1; in_rs_data = 1; in_imm_ext = 32'hFFFF_FFFE;
    in_rt_addr = 5'd4; in_rd_addr = 5'd9; in_reg_write = 1;
    tick();
    chk("addi_result", out_alu_result, 32'hFFFF_FFFF);
    chk("addi_dest", {27'd0, out_dest}, 32'd4);

    rvec("r_sub", 3'b010, 32'h22, 32'd10, 32'd3, 32'd7);
    rvec("r_and", 3'b010, 32'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    rvec("r_or", 3'b010, 32'h25, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    rvec("r_nor", 3'b010, 32'h27, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F);
    rvec("r_slt_neg", 3'b010, 32'h2A, 32'hFFFF_FFFF, 32'd1, 32'd1);
    rvec("r_slt_pos", 3'b010, 32'h2A, 32'd1, 32'hFFFF_FFFF, 32'd0);
    rvec("r_unknown", 3'b010, 32'h3F, 32'd2, 32'd3, 32'd5);
    rvec("op_sub", 3'b001, 32'h0, 32'd0, 32'd1, 32'hFFFF_FFFF);
    rvec("op_and", 3'b011, 32'h0, 32'hC, 32'hA, 32'h8);
    rvec("op_or", 3'b100, 32'h0, 32'hC, 32'hA, 32'hE);
    rvec("op_slt", 3'b101, 32'h0, 32'h8000_0000, 32'd0, 32'd1);
    rvec("op_lui", 3'b110, 32'h0000_ABCD, 32'h1234_5678, 32'd0, 32'hABCD_0000);
    rvec("op_111", 3'b111, 32'h0, 32'hFFFF_FFFF, 32'd2, 32'd1);
`ifndef MULT_EN
    rvec("funct18_add", 3'b010, 32'h18, 32'd3, 32'd4, 32'd7);
    chk("funct18_stall", {31'd0, out_stall}, 32'd0);
`endif

    // store: data passes rt through
    clear_in();
    in_valid = 1; in_alu_src = 1; in_rs_data = 32'h100; in_imm_ext = 32'h8;
    in_rt_data = 32'hDEAD_BEEF; in_mem_write = 1;
    tick();
    chk("sw_addr", out_alu_result, 32'h108);
    chk("sw_data", out_store_data, 32'hDEAD_BEEF);
    chk("sw_mw", {31'd0, out_mem_write}, 32'd1);

    // beq taken, then one-cycle pulse
    clear_in();
    in_valid = 1; in_alu_op = 3'b001; in_branch = 1; in_rs_data = 9; in_rt_data = 9;
    in_pc_plus4 = 32'h100; in_imm_ext = 32'd4;
    tick();
    chk("beq_redir", {31'd0, out_redirect}, 32'd1);
    chk("beq_target", out_pc_target, 32'h110);
    clear_in();
    tick();
    chk("beq_pulse", {31'd0, out_redirect}, 32'd0);

    // beq not taken
    clear_in();
    in_valid = 1; in_alu_op = 3'b001; in_branch = 1; in_rs_data = 9; in_rt_data = 8;
    in_pc_plus4 = 32'h100; in_imm_ext = 32'd4;
    tick();
    chk("bne_redir", {31'd0, out_redirect}, 32'd0);

    // bubble carrying jump/branch and controls
    clear_in();
    in_jump = 1; in_branch = 1; in_rs_data = 5; in_rt_data = 5; in_jump_target = 32'h400;
    in_reg_write = 1; in_mem_read = 1; in_mem_write = 1; in_mem_to_reg = 1;
    tick();
    chk("bub_ctrl", {27'd0, out_redirect, out_reg_write, out_mem_read, out_mem_write,
                     out_mem_to_reg}, 32'd0);

    // jump wins over taken branch
    in_valid = 1; in_reg_write = 0; in_mem_read = 0; in_mem_write = 0; in_mem_to_reg = 0;
    in_pc_plus4 = 32'h200; in_imm_ext = 32'd8;
    tick();
    chk("jmp_redir", {31'd0, out_redirect}, 32'd1);
    chk("jmp_target", out_pc_target, 32'h400);
    clear_in();
    tick();
    chk("jmp_pulse", {31'd0, out_redirect}, 32'd0);

`ifdef MULT_EN
    clear_in();
    in_valid = 1; in_alu_op = 3'b010; in_imm_ext = 32'h18; in_rs_data = 3;
    in_rt_data = 32'h8000_0001; in_reg_dst = 1; in_rd_addr = 5'd5; in_reg_write = 1;
    tick();
    clear_in();
    stall_cnt = 0;
    while (out_stall && stall_cnt < 40) begin
      stall_cnt++;
      tick();
    end
    chk("mul_stall_len", stall_cnt, 32'd33);
    chk("mul_result", out_alu_result, 32'h8000_0003);
    chk("mul_dest", {27'd0, out_dest}, 32'd5);
    chk("mul_rw", {31'd0, out_reg_write}, 32'd1);

    // reset mid-multiply
    in_valid = 1; in_alu_op = 3'b010; in_imm_ext = 32'h18; in_rs_data = 7; in_rt_data = 9;
    in_reg_dst = 1; in_rd_addr = 5'd6; in_reg_write = 1;
    tick();
    clear_in();
    repeat (9) tick();
    chk("mul_mid_stall", {31'd0, out_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mul_rst_stall", {31'd0, out_stall}, 32'd0);
    chk("mul_rst_ctrl", {30'd0, out_redirect, out_reg_write}, 32'd0);
    tick();
    rst_n = 1'b1;
    rvec("post_rst_add", 3'b000, 32'h0, 32'd20, 32'd22, 32'd42);
    chk("post_rst_stall", {31'd0, out_stall}, 32'd0);
`else
    stall_cnt = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {31'd0, out_reg_write}, {31'd0, 1'b0} | {31'd0, stall_cnt[0]});
    tick();
    rst_n = 1'b1;
    rvec("post_rst_add", 3'b000, 32'h0, 32'd20, 32'd22, 32'd42);
`endif

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the MIPS32 pipeline. It consumes the registered ID/EX bundle, produces the ALU result, resolves branches and jumps, and registers everything into the EX/MEM bundle. It raises a one-cycle redirect/flush toward IF/ID when control flow changes. It can optionally hold the pipeline for an iterative multiply.

## Interface
- Parameters: none (widths fixed by the pipeline package)
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ID/EX slot holds a real instruction (0 = bubble)
- in_pc_plus4, in_rs_data, in_rt_data, in_imm_ext, in_jump_target  in  32 each  ID/EX datapath fields
- in_rt_addr, in_rd_addr  in  5 each  destination candidates
- in_reg_dst, in_branch, in_mem_read, in_mem_write, in_alu_src, in_reg_write, in_mem_to_reg, in_jump  in  1 each  ID/EX control
- in_alu_op  in  3  ALU operation class
- out_alu_result, out_store_data  out  32 each  EX/MEM datapath
- out_dest  out  5  selected write register
- out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  out  1 each  EX/MEM control
- out_redirect  out  1  one-cycle pulse: fetch from out_pc_target, flush IF/ID and ID/EX
- out_pc_target  out  32  redirect address
- out_stall  out  1  hold PC, IF/ID and ID/EX (multiply busy)

## Operation
- Operand B = in_alu_src ? in_imm_ext : in_rt_data. Dest = in_reg_dst ? in_rd_addr : in_rt_addr.
- ALU op map:
  - 000 = add
  - 001 = sub
  - 010 = R-type, decoded from funct = in_imm_ext[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed); any other funct gives add
  - 011 = and
  - 100 = or
  - 101 = slt
  - 110 = lui, which yields {imm[15:0],16'h0}
  - 111 = add
- All arithmetic is 32-bit wrap-around. Overflow is ignored.
- zero = (sub result == 0). Branch taken = in_valid & in_branch & zero. Target = in_pc_plus4 + (in_imm_ext << 2), with bits 31:0 kept.
- Jump = in_valid & in_jump. Target = in_jump_target. When both branch and jump are set, jump wins.
- A taken branch or jump registers out_redirect=1 and out_pc_target for exactly one cycle. The instruction itself still passes to EX/MEM with its own controls; a jump has reg_write=0 from decode.
- A bubble (in_valid=0) registers all EX/MEM control outputs as 0. Data outputs are don't-care but deterministic: they pass through.
- out_store_data = in_rt_data.

## Timing
- Reset values: every output is 0 and the multiply FSM is IDLE.
- Latency: inputs are sampled at posedge N, and results and redirect are visible after posedge N. The redirect pulse lasts one cycle.
- A redirect does not squash the instruction being registered in the same edge. The upstream flush acts on the younger slots only.
- Reset asserted mid-operation clears the FSM, stall and redirect immediately (asynchronously).

## Configuration
- MULT_EN defined:
  - R-type funct 0x18 runs an iterative shift-add multiply. The low 32 bits of rs*rt are written to rd; signedness is irrelevant for the low word.
  - FSM states:
    - IDLE: on a valid mult, capture the operands and go to BUSY. out_stall=1 from the cycle the mult is presented.
    - BUSY: 32 iterations with a 5-bit counter, emitting EX/MEM bubbles. After the counter reaches 31, go to DONE.
    - DONE: register the product with the mult's dest/reg_write, drop out_stall, return to IDLE.
  - Total: mult accepted at edge N, result in EX/MEM after edge N+33, out_stall high for cycles N..N+32.
  - The stalled ID/EX inputs are held by upstream and ignored while BUSY/DONE.
- MULT_EN undefined: funct 0x18 decodes as add, out_stall is tied to 0, and no FSM exists.

## Structure
- Shared pipeline package holds:
  - ALUOp encodings (ALUOP_ADD … ALUOP_LUI)
  - funct constants
  - the internal 4-bit ALU control enum
  - the multiply FSM state enum
- One sub-module, alu_core: combinational op-select over 32-bit A/B producing result and zero. The FSM and registers stay in ex_stage.

## Test plan
- add: alu_op=010, funct 0x20, rs=5, rt=7, reg_dst=1, rd=3, reg_write=1 -> after one edge out_alu_result=12, out_dest=3, out_reg_write=1, out_redirect=0.
- addi negative: alu_src=1, rs=1, imm=32'hFFFF_FFFE -> 32'hFFFF_FFFF.
- slt signed: rs=32'hFFFF_FFFF, rt=1 -> 1.
- beq taken: rs=rt=9, branch=1, pc_plus4=0x100, imm=4 -> out_redirect=1 for exactly one cycle, out_pc_target=0x110. With rt=8 instead -> out_redirect stays 0.
- Jump with branch set and in_valid=0: in_valid=0 -> no redirect and all control outputs 0. Then in_valid=1, jump=1, branch=1 (equal operands), jump_target=0x400 -> out_pc_target=0x400.
- MULT_EN: rs=3, rt=32'h8000_0001 -> out_stall high 33 cycles, bubbles in between, then out_alu_result=32'h8000_0003. Assert rst_n=0 at cycle 10 -> out_stall=0 and FSM IDLE immediately.
